// File: rtl/pipe_spawner.sv
// pipe_spawner: source end of the obstacle light chain. Emits one-cycle
//   column pulses (all rows lit except a pseudo-random GAP-row opening) that
//   feed the rightOn inputs of the rightmost light-cell column.
// Ports: clk/reset (async, active-high); enable = step strobe; start = leave
//   IDLE; lose = freeze; column/spawned = registered one-cycle emission;
//   running = not IDLE; pipes_sent = saturating pipe count.
module pipe_spawner #(
  parameter int unsigned ROWS    = 8,
  parameter int unsigned GAP     = 3,
  parameter int unsigned SPACING = 4,
  parameter logic [7:0]  SEED    = 8'hA5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            start,
  input  logic            lose,
  output logic [ROWS-1:0] column,
  output logic            spawned,
  output logic            running,
  output logic [7:0]      pipes_sent
);

  localparam int unsigned W  = $clog2(ROWS);
  localparam int unsigned CW = (SPACING > 0) ? $clog2(SPACING + 1) : 1;
  localparam int unsigned SPAN = ROWS - GAP;

  // Elaboration-time sanity checks on the parameter set.
  generate
    if (GAP < 1 || GAP >= ROWS) begin : g_bad_gap
      $error("pipe_spawner: GAP must satisfy 1 <= GAP < ROWS");
    end
    if (2 * (ROWS - GAP) < (1 << W) - 1) begin : g_bad_fold
      $error("pipe_spawner: 2*(ROWS-GAP) must be >= 2^W - 1");
    end
    if (SEED == 8'h00) begin : g_bad_seed
      $error("pipe_spawner: SEED must be nonzero");
    end
  endgenerate

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      lfsr_q, lfsr_d;
  logic [7:0]      pipes_q, pipes_d;
  logic [ROWS-1:0] column_q, column_d;
  logic            spawned_q, spawned_d;

  logic [W:0]      pos_raw;
  logic [W:0]      pos;
  logic [ROWS-1:0] gap_col;
  logic [7:0]      lfsr_next;

  // Fibonacci LFSR step; only taken when a pipe is emitted.
  assign lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  // Gap start row. The raw LFSR slice can exceed the last legal start row,
  // so out-of-range values are folded back down by SPAN.
  always_comb begin
    pos_raw = {1'b0, lfsr_q[W-1:0]};
    if (pos_raw > (W+1)'(SPAN)) begin
      pos = pos_raw - (W+1)'(SPAN);
    end else begin
      pos = pos_raw;
    end
    gap_col = '0;
    for (int r = 0; r < int'(ROWS); r++) begin
      gap_col[r] = !((r >= int'(pos)) && (r <= int'(pos) + int'(GAP) - 1));
    end
  end

  // Next-state / emission logic. column and spawned default to 0 so a pulse
  // lasts exactly one cycle; lose blocks every other update.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lfsr_d    = lfsr_q;
    pipes_d   = pipes_q;
    column_d  = '0;
    spawned_d = 1'b0;

    if (!lose) begin
      case (state_q)
        IDLE: begin
          // An enable arriving with start is deliberately not counted.
          if (start) begin
            state_d = RUN;
            cnt_d   = CW'(SPACING);
          end
        end
        RUN: begin
          if (enable) begin
            if (cnt_q == '0) begin
              column_d  = gap_col;
              spawned_d = 1'b1;
              cnt_d     = CW'(SPACING);
              lfsr_d    = lfsr_next;
              if (pipes_q != 8'hFF) begin
                pipes_d = pipes_q + 8'd1;
              end
            end else begin
              cnt_d = cnt_q - CW'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= CW'(SPACING);
      lfsr_q    <= SEED;
      pipes_q   <= 8'd0;
      column_q  <= '0;
      spawned_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lfsr_q    <= lfsr_d;
      pipes_q   <= pipes_d;
      column_q  <= column_d;
      spawned_q <= spawned_d;
    end
  end

  assign column     = column_q;
  assign spawned    = spawned_q;
  assign running    = (state_q == RUN);
  assign pipes_sent = pipes_q;

endmodule

// File: tb/tb_pipe_spawner.sv
module tb_pipe_spawner;

  localparam int R  = 8;
  localparam int G  = 3;
  localparam int SP = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0, st = 1'b0, ls = 1'b0;
  logic [7:0] col0, col1, ps0, ps1;
  logic       sp0, sp1, run0, run1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_spawner u_dut0 (
    .clk(clk), .reset(rst), .enable(en), .start(st), .lose(ls),
    .column(col0), .spawned(sp0), .running(run0), .pipes_sent(ps0)
  );

  // Same design with no spacing: one pipe per counted enable.
  pipe_spawner #(.SPACING(0)) u_dut1 (
    .clk(clk), .reset(rst), .enable(en), .start(st), .lose(ls),
    .column(col1), .spawned(sp1), .running(run1), .pipes_sent(ps1)
  );

  // Reference model: counts enables since start and emits on every
  // (spacing+1)-th one; gap column built from a shifted mask.
  typedef struct {
    bit         run;
    int         k;
    logic [7:0] lfsr;
    int         pipes;
    logic [7:0] col;
    bit         sp;
  } mdl_t;

  mdl_t m0, m1;

  function automatic mdl_t mreset();
    mdl_t m;
    m.run = 0; m.k = 0; m.lfsr = 8'hA5; m.pipes = 0; m.col = 8'h00; m.sp = 0;
    return m;
  endfunction

  function automatic logic [7:0] gap_col(logic [7:0] l);
    int pos;
    logic [7:0] mask;
    pos = int'(l[2:0]);
    if (pos > R - G) pos = pos - (R - G);
    mask = 8'(((1 << G) - 1) << pos);
    return ~mask;
  endfunction

  function automatic mdl_t mstep(mdl_t mi, int spacing, bit e, bit s, bit l);
    mdl_t m;
    m = mi;
    m.col = 8'h00;
    m.sp  = 0;
    if (l) return m;
    if (!m.run) begin
      if (s) begin
        m.run = 1;
        m.k   = 0;
      end
      return m;
    end
    if (e) begin
      m.k = m.k + 1;
      if (m.k % (spacing + 1) == 0) begin
        m.col  = gap_col(m.lfsr);
        m.sp   = 1;
        m.lfsr = {m.lfsr[6:0], m.lfsr[7] ^ m.lfsr[5] ^ m.lfsr[4] ^ m.lfsr[3]};
        if (m.pipes < 255) m.pipes = m.pipes + 1;
      end
    end
    return m;
  endfunction

  // 1 when c has exactly G zero bits and they are contiguous.
  function automatic int good_shape(logic [7:0] c);
    int zeros;
    int first;
    logic [7:0] z;
    zeros = 0;
    first = -1;
    for (int i = 0; i < R; i++) begin
      if (!c[i]) begin
        zeros++;
        if (first < 0) first = i;
      end
    end
    if (zeros != G) return 0;
    z = ~c;
    return ((z >> first) == 8'(((1 << G) - 1))) ? 1 : 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_all();
    chk("col0", int'(col0), int'(m0.col));
    chk("sp0",  int'(sp0),  int'(m0.sp));
    chk("run0", int'(run0), int'(m0.run));
    chk("ps0",  int'(ps0),  m0.pipes);
    chk("col1", int'(col1), int'(m1.col));
    chk("sp1",  int'(sp1),  int'(m1.sp));
    chk("run1", int'(run1), int'(m1.run));
    chk("ps1",  int'(ps1),  m1.pipes);
    if (sp1) chk("shape1", good_shape(col1), 1);
  endtask

  // One clock: drive at negedge, step model at posedge, check at negedge.
  task automatic cyc(input bit e, input bit s, input bit l);
    en = e; st = s; ls = l;
    @(posedge clk);
    m0 = mstep(m0, SP, e, s, l);
    m1 = mstep(m1, 0, e, s, l);
    @(negedge clk);
    cmp_all();
  endtask

  task automatic do_reset();
    en = 0; st = 0; ls = 0;
    rst = 1'b1;
    #1;
    m0 = mreset();
    m1 = mreset();
    cmp_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    bit         e, s, l;
    logic [7:0] col;
    bit         sp, run;
    logic [7:0] ps;
  } vec_t;

  vec_t vt[$];

  task automatic add(input bit e, input bit s, input bit l,
                     input logic [7:0] c, input bit p, input bit r, input logic [7:0] n);
    vec_t v;
    v.e = e; v.s = s; v.l = l; v.col = c; v.sp = p; v.run = r; v.ps = n;
    vt.push_back(v);
  endtask

  initial begin
    int lose_left;
    bit re, rs, rl;

    // Idle with enable pulsing, start low: nothing happens.
    for (int i = 0; i < 10; i++) add(bit'(i % 2), 0, 0, 8'h00, 0, 0, 8'd0);
    // Start together with enable: that enable is not counted.
    add(1, 1, 0, 8'h00, 0, 1, 8'd0);
    for (int i = 0; i < 4; i++) add(1, 0, 0, 8'h00, 0, 1, 8'd0);
    add(1, 0, 0, 8'h1F, 1, 1, 8'd1);          // lfsr A5 -> gap rows 5-7
    add(0, 0, 0, 8'h00, 0, 1, 8'd1);
    for (int i = 0; i < 4; i++) add(1, 0, 0, 8'h00, 0, 1, 8'd1);
    add(1, 0, 0, 8'hE3, 1, 1, 8'd2);          // lfsr 4A -> gap rows 2-4
    for (int i = 0; i < 2; i++) add(1, 0, 0, 8'h00, 0, 1, 8'd2);
    for (int i = 0; i < 6; i++) add(1, bit'(i == 2), 1, 8'h00, 0, 1, 8'd2);
    for (int i = 0; i < 2; i++) add(1, 0, 0, 8'h00, 0, 1, 8'd2);
    add(1, 0, 0, 8'h1F, 1, 1, 8'd3);          // lfsr 95 -> gap rows 5-7
    add(0, 0, 0, 8'h00, 0, 1, 8'd3);

    #2;
    do_reset();

    foreach (vt[i]) begin
      cyc(vt[i].e, vt[i].s, vt[i].l);
      chk($sformatf("vec%0d_col", i), int'(col0), int'(vt[i].col));
      chk($sformatf("vec%0d_sp", i),  int'(sp0),  int'(vt[i].sp));
      chk($sformatf("vec%0d_run", i), int'(run0), int'(vt[i].run));
      chk($sformatf("vec%0d_ps", i),  int'(ps0),  int'(vt[i].ps));
    end

    // Asynchronous reset while the first pipe is on the output.
    do_reset();
    cyc(0, 1, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0);
    cyc(1, 0, 0);
    chk("areset_pre_col", int'(col0), 8'h1F);
    rst = 1'b1;
    #1;
    chk("areset_col", int'(col0), 0);
    chk("areset_sp",  int'(sp0),  0);
    chk("areset_run", int'(run0), 0);
    chk("areset_col1", int'(col1), 0);
    m0 = mreset();
    m1 = mreset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc(0, 1, 0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0);
    chk("after_reset_pipe", int'(col0), 8'h1F);

    // Randomized traffic with bursty lose and sporadic start.
    lose_left = 0;
    for (int i = 0; i < 600; i++) begin
      re = ($urandom_range(0, 99) < 60);
      rs = ($urandom_range(0, 99) < 5);
      if (lose_left > 0) begin
        rl = 1;
        lose_left--;
      end else if ($urandom_range(0, 99) < 4) begin
        rl = 1;
        lose_left = $urandom_range(1, 6);
      end else begin
        rl = 0;
      end
      cyc(re, rs, rl);
    end

    // Saturation: well over 255 emissions on the zero-spacing instance.
    do_reset();
    cyc(0, 1, 0);
    for (int i = 0; i < 300; i++) cyc(1, 0, 0);
    chk("sat_ps1", int'(ps1), 255);
    cyc(0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
